// File: rtl/fpga_dsp_pkg.sv
// Shared types and width constants for the multi-channel FPGA-to-DSP address generator.
package fpga_dsp_pkg;

    localparam int PKG_ADDR_W = 16;
    localparam int PKG_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BURST,
        DONE
    } state_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] base;
        logic [PKG_LEN_W-1:0]  len;
    } ch_req_t;

endpackage

// File: rtl/fpga_dsp_rr_arb.sv
// Round-robin arbiter: searches the request vector from the slot after the last grant.
module fpga_dsp_rr_arb
#(
    parameter int  NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any_req
);

    // ptr holds the first channel to consider, i.e. last grant + 1
    logic [CH_W-1:0] ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_req && req[(int'(ptr) + k) % NUM_CH]) begin
                any_req = 1'b1;
                grant_idx = CH_W'((int'(ptr) + k) % NUM_CH);
                grant[(int'(ptr) + k) % NUM_CH] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv && any_req) begin
            ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
        end
    end

endmodule

// File: rtl/fpga_dsp_addr_gen.sv
// Multi-channel FPGA-to-DSP burst address generator with round-robin channel service.
// Optional FPGA_DSP_ADDR_WRAP_EN: addresses wrap inside an aligned 2**WIN_W window.
module fpga_dsp_addr_gen
    import fpga_dsp_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  ADDR_W = PKG_ADDR_W,
    parameter int  LEN_W  = PKG_LEN_W,
    parameter int  STRIDE = 1,
    parameter int  WIN_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_CH-1:0]        Start,
    input  logic [NUM_CH*ADDR_W-1:0] Base,
    input  logic [NUM_CH*LEN_W-1:0]  Len,
    output logic [ADDR_W-1:0]        Addr,
    output logic [CH_W-1:0]          Addr_Ch,
    output logic                     Addr_Valid,
    input  logic                     Addr_Ready,
    output logic [NUM_CH-1:0]        Busy,
    output logic [NUM_CH-1:0]        Int_Sig
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    state_t              state, next;
    ch_req_t             req [NUM_CH];
    logic [NUM_CH-1:0]   busy, accept, done_oh, grant;
    logic [CH_W-1:0]     grant_idx, ch;
    logic                any_req;
    logic [ADDR_W-1:0]   cur_base, off;
    logic [LEN_W-1:0]    cnt;

    // A channel already busy (including one in DONE) ignores Start, so the DONE clear wins
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_CH; i++)
            accept[i] = Start[i] && !busy[i] && (Len[i*LEN_W +: LEN_W] != '0);
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                req[i].base <= PKG_ADDR_W'(Base[i*ADDR_W +: ADDR_W]);
                req[i].len  <= PKG_LEN_W'(Len[i*LEN_W +: LEN_W]);
            end
        end
    end

    fpga_dsp_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .req       (busy),
        .adv       (state == ARB),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        next       = state;
        Addr_Valid = 1'b0;
        Int_Sig    = '0;
        case (state)
            IDLE:  if (|busy) next = ARB;
            ARB:   next = any_req ? BURST : IDLE;
            BURST: begin
                Addr_Valid = 1'b1;
                if (Addr_Ready && cnt == LEN_W'(1)) next = DONE;
            end
            DONE: begin
                Int_Sig = done_oh;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            busy     <= '0;
            cur_base <= '0;
            off      <= '0;
            cnt      <= '0;
            ch       <= '0;
            done_oh  <= '0;
        end else begin
            state <= next;
            busy  <= (busy | accept) & ~Int_Sig;
            if (state == ARB) begin
                cur_base <= ADDR_W'(req[grant_idx].base);
                cnt      <= LEN_W'(req[grant_idx].len);
                off      <= '0;
                ch       <= grant_idx;
                done_oh  <= grant;
            end else if (Addr_Valid && Addr_Ready) begin
                off <= off + STEP;
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

`ifdef FPGA_DSP_ADDR_WRAP_EN
    // Span is one bit wider so WIN_W == ADDR_W yields an all-ones mask
    localparam logic [ADDR_W:0]   WIN_SPAN = (ADDR_W+1)'(1) << WIN_W;
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WIN_SPAN - (ADDR_W+1)'(1));

    assign Addr = (cur_base & ~WIN_MASK) | ((cur_base + off) & WIN_MASK);
`else
    logic unused_win;

    assign unused_win = (WIN_W > ADDR_W);
    assign Addr       = cur_base + off;
`endif

    assign Addr_Ch = ch;
    assign Busy    = busy;

endmodule
